bsg_trace_recorder: RTL and testbench
=====================================

BSG_TRACE_RECORDER -- requirements
Module: bsg_trace_recorder

Interface
REQ-001 SHALL have parameter payload_width_p, default 32, meaning the recorded data width and the gap counter width.
REQ-002 SHALL have parameter mem_addr_width_p, default 6, meaning the trace memory address width (2^A entries).
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port reset_i, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port en_i, input, 1, recording enable.
REQ-006 SHALL have port record_gaps_i, input, 1; when 1, idle gaps are encoded as cycle-wait entries.
REQ-007 SHALL have port v_i, input, 1, valid of the observed sink channel.
REQ-008 SHALL have port data_i, input, payload_width_p, payload of the sink channel.
REQ-009 SHALL have port ready_and_o, output, 1; a handshake is v_i & ready_and_o.
REQ-010 SHALL have port finish_i, input, 1, pulse that terminates the trace.
REQ-011 SHALL have port mem_v_o, output, 1, trace memory write strobe (synchronous write).
REQ-012 SHALL have port mem_addr_o, output, mem_addr_width_p, write address.
REQ-013 SHALL have port mem_data_o, output, payload_width_p+4, trace word {op[3:0], payload}.
REQ-014 SHALL have port done_o, output, 1, trace terminated.
REQ-015 SHALL have port overflow_o, output, 1, trace truncated by capacity.

Function
REQ-016 SHALL use trace op codes identical to trace replay: RECV=4'd1, FINISH=4'd3, WAIT=4'd4, CYCLE_INIT=4'd5.
REQ-017 SHALL implement states IDLE, GAP_INIT, GAP_WAIT, DATA, FIN, DONE.
REQ-018 SHALL drive ready_and_o=1 only in IDLE with en_i=1 and mem_addr_o < 2^A-3.
REQ-019 SHALL count, in a saturating gap counter (max 2^payload_width_p-1), IDLE cycles with en_i=1 and no handshake, and clear it on each handshake.
REQ-020 SHALL, on a handshake with gap=0 or record_gaps_i=0, write {RECV,data_i} at mem_addr_o in the same cycle, increment the address, and stay in IDLE (zero-latency, full throughput).
REQ-021 SHALL, on a handshake with gap>0 and record_gaps_i=1, capture data_i and write in three consecutive cycles: {CYCLE_INIT,gap} (GAP_INIT), {WAIT,0} (GAP_WAIT), {RECV,captured} (DATA), then return to IDLE; ready_and_o=0 throughout.
REQ-022 SHALL, in IDLE, enter FIN when finish_i=1 or mem_addr_o >= 2^A-3; FIN writes {FINISH,0} at the current address, then enters DONE.
REQ-023 SHALL, if finish_i and a handshake coincide, record the handshake first (including any gap sequence) and then write FINISH; finish_i arriving during GAP_*/DATA SHALL be latched and honored.
REQ-024 SHALL set overflow_o=1 when FIN is entered due to capacity rather than finish_i.
REQ-025 SHALL, in DONE, hold done_o=1, mem_v_o=0, ready_and_o=0, and ignore all inputs until reset.
REQ-026 SHALL, with en_i=0, freeze the gap counter and not accept handshakes; in-flight GAP_*/DATA sequences SHALL complete regardless of en_i.
REQ-027 SHALL assert mem_v_o exactly in the cycles that write a word; mem_addr_o SHALL never wrap.

Reset
REQ-028 SHALL, on reset_i, immediately force state=IDLE, address=0, gap=0, finish latch=0, mem_v_o=0, done_o=0, overflow_o=0, ready_and_o=0 (until reset deasserts).
REQ-029 SHALL, on reset mid-sequence, abandon the partial gap/data sequence with no further writes.

Structure
REQ-030 SHALL take op codes and the trace word layout from the shared package bsg_trace_pkg, shared with trace replay.
REQ-031 SHALL place the saturating gap counter in sub-module bsg_trace_recorder_gap_ctr.

Verification (payload_width_p=32, mem_addr_width_p=6)
REQ-032 SHALL check back-to-back: v_i=1 for 3 cycles with data 0xA, 0xB, 0xC and gap=0 -> RECV words at addresses 0, 1, 2 in the same cycles as the handshakes.
REQ-033 SHALL check gap: 5 idle cycles, then data 0x55 with record_gaps_i=1 -> {5,5}, {4,0}, {1,0x55} at addresses 0-2, with ready_and_o low for 3 cycles.
REQ-034 SHALL check capacity: 70 continuous handshakes -> 61 RECV words at addresses 0-60, FINISH at 61, overflow_o=1, done_o=1.
REQ-035 SHALL check collision: finish_i with a handshake after a gap of 2 -> INIT(2), WAIT, RECV, FINISH at addresses 0-3, overflow_o=0.
REQ-036 SHALL check reset mid-sequence: reset_i asserted during GAP_WAIT -> no DATA write, address=0 and all outputs 0 immediately.
REQ-037 SHALL check round trip: feed the recorded memory to trace replay as a response ROM -> replay ends with done_o=1 and error_o=0.

Source files
------------

// File: rtl/bsg_trace_pkg.sv
// Trace format package, shared by the trace recorder and trace replay.
// A trace word is {op[3:0], payload}: op in the top bits, payload below.
package bsg_trace_pkg;

  localparam int trace_op_width_gp = 4;

  typedef enum logic [trace_op_width_gp-1:0] {
    TRACE_OP_RECV       = 4'd1,
    TRACE_OP_FINISH     = 4'd3,
    TRACE_OP_WAIT       = 4'd4,
    TRACE_OP_CYCLE_INIT = 4'd5
  } trace_op_e;

endpackage

// File: rtl/bsg_trace_recorder_gap_ctr.sv
// Saturating idle-gap counter.
//   clk_i, reset_i : clock, async active-high reset
//   clr_i          : clear to zero (wins over inc_i)
//   inc_i          : count one idle cycle; holds at all-ones
//   count_o        : current gap count
module bsg_trace_recorder_gap_ctr #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                        count_o <= '0;
    else if (clr_i)                     count_o <= '0;
    else if (inc_i && (count_o != '1))  count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bsg_trace_recorder.sv
// Trace recorder: observes a valid/ready sink channel and writes a replayable
// trace into a synchronous-write memory.
//   clk_i, reset_i          : clock, async active-high reset
//   en_i, record_gaps_i     : recording enable, encode idle gaps as waits
//   v_i, data_i, ready_and_o: observed sink channel (handshake = v_i & ready_and_o)
//   finish_i                : terminate the trace
//   mem_v_o/addr_o/data_o   : trace memory write port, word = {op, payload}
//   done_o, overflow_o      : trace terminated / terminated by capacity
module bsg_trace_recorder
  import bsg_trace_pkg::*;
#(
  parameter int payload_width_p  = 32,
  parameter int mem_addr_width_p = 6
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic                                         en_i,
  input  logic                                         record_gaps_i,
  input  logic                                         v_i,
  input  logic [payload_width_p-1:0]                   data_i,
  output logic                                         ready_and_o,
  input  logic                                         finish_i,
  output logic                                         mem_v_o,
  output logic [mem_addr_width_p-1:0]                  mem_addr_o,
  output logic [payload_width_p+trace_op_width_gp-1:0] mem_data_o,
  output logic                                         done_o,
  output logic                                         overflow_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP_INIT, S_GAP_WAIT, S_DATA, S_FIN, S_DONE
  } state_e;

  // Handshakes stop 3 entries short of the end: the worst case after the last
  // accepted handshake is a 3-word gap sequence plus FINISH, which fits exactly.
  localparam logic [mem_addr_width_p-1:0] limit_lp =
    mem_addr_width_p'((1 << mem_addr_width_p) - 3);

  state_e                       state_q, state_d;
  logic [mem_addr_width_p-1:0]  addr_q, addr_d;
  logic [payload_width_p-1:0]   data_q, data_d;
  logic                         fin_q, fin_d;
  logic                         ovf_q, ovf_d;
  logic                         gap_inc, gap_clr;
  logic [payload_width_p-1:0]   gap;

  bsg_trace_recorder_gap_ctr #(.width_p(payload_width_p)) gap_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (gap_clr),
    .inc_i   (gap_inc),
    .count_o (gap)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      fin_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fin_q   <= fin_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    fin_d       = fin_q;
    ovf_d       = ovf_q;
    ready_and_o = 1'b0;
    mem_v_o     = 1'b0;
    mem_data_o  = '0;
    done_o      = 1'b0;
    gap_inc     = 1'b0;
    gap_clr     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // State sits in IDLE while reset is held; keep the channel closed then.
        ready_and_o = ~reset_i & en_i & (addr_q < limit_lp);
        if (v_i & ready_and_o) begin
          if ((gap != '0) && record_gaps_i) begin
            // Gap counter is cleared when DATA retires so GAP_INIT still sees it.
            data_d  = data_i;
            fin_d   = finish_i;
            state_d = S_GAP_INIT;
          end else begin
            mem_v_o    = 1'b1;
            mem_data_o = {TRACE_OP_RECV, data_i};
            addr_d     = addr_q + mem_addr_width_p'(1);
            gap_clr    = 1'b1;
            if (finish_i) state_d = S_FIN;
          end
        end else begin
          gap_inc = en_i;
          if (finish_i) begin
            state_d = S_FIN;
          end else if (addr_q >= limit_lp) begin
            state_d = S_FIN;
            ovf_d   = 1'b1;
          end
        end
      end
      S_GAP_INIT: begin
        mem_v_o    = 1'b1;
        mem_data_o = {TRACE_OP_CYCLE_INIT, gap};
        addr_d     = addr_q + mem_addr_width_p'(1);
        fin_d      = fin_q | finish_i;
        state_d    = S_GAP_WAIT;
      end
      S_GAP_WAIT: begin
        mem_v_o    = 1'b1;
        mem_data_o = {TRACE_OP_WAIT, {payload_width_p{1'b0}}};
        addr_d     = addr_q + mem_addr_width_p'(1);
        fin_d      = fin_q | finish_i;
        state_d    = S_DATA;
      end
      S_DATA: begin
        mem_v_o    = 1'b1;
        mem_data_o = {TRACE_OP_RECV, data_q};
        addr_d     = addr_q + mem_addr_width_p'(1);
        gap_clr    = 1'b1;
        fin_d      = 1'b0;
        state_d    = (fin_q | finish_i) ? S_FIN : S_IDLE;
      end
      S_FIN: begin
        // Last word of the trace; address is not advanced so it never wraps.
        mem_v_o    = 1'b1;
        mem_data_o = {TRACE_OP_FINISH, {payload_width_p{1'b0}}};
        state_d    = S_DONE;
      end
      S_DONE: done_o = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_addr_o = addr_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bsg_trace_recorder.sv
module tb_bsg_trace_recorder;

  localparam int PW = 32;
  localparam int AW = 6;
  localparam int DW = PW + 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          en_i = 1'b0, record_gaps_i = 1'b0, v_i = 1'b0, finish_i = 1'b0;
  logic [PW-1:0] data_i = '0;
  logic          ready_and_o, mem_v_o, done_o, overflow_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;

  bsg_trace_recorder #(.payload_width_p(PW), .mem_addr_width_p(AW)) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .record_gaps_i(record_gaps_i),
    .v_i(v_i), .data_i(data_i), .ready_and_o(ready_and_o), .finish_i(finish_i),
    .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    rec_mem [0:(1<<AW)-1];
  logic             s_ready, s_memv;

  function automatic logic [AW+DW-1:0] word(int a, int op, logic [PW-1:0] p);
    logic [3:0] o;
    o = 4'(op);
    return {AW'(a), o, p};
  endfunction

  // One clock: sample at the falling edge, pop the scoreboard on every write,
  // then return just after the rising edge so the caller can drive inputs.
  task automatic cycle();
    logic [AW+DW-1:0] e;
    @(negedge clk);
    s_ready = ready_and_o;
    s_memv  = mem_v_o;
    if (mem_v_o) begin
      rec_mem[mem_addr_o] = mem_data_o;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write got addr=%0d data=%h, expected no write", mem_addr_o, mem_data_o);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr_o, mem_data_o} !== e) begin
          n_fail++;
          $display("FAIL sb_word got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr_o, mem_data_o, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset_i = 1'b1; en_i = 1'b0; record_gaps_i = 1'b0; v_i = 1'b0; finish_i = 1'b0; data_i = '0;
    exp_q.delete();
    for (int i = 0; i < (1<<AW); i++) rec_mem[i] = '0;
    cycle(); cycle();
    reset_i = 1'b0;
  endtask

  task automatic drain_check(string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got %0d words pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; en_i = 1'b1; v_i = 1'b1; data_i = 32'h1234;
    #2;
    n_tests++;
    if ({ready_and_o, mem_v_o, done_o, overflow_o, mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b v=%b done=%b ovf=%b addr=%0d, expected all 0",
               ready_and_o, mem_v_o, done_o, overflow_o, mem_addr_o);
    end
    reset_dut();
  endtask

  task automatic test_back_to_back();
    reset_dut();
    en_i = 1'b1; record_gaps_i = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(word(i, 1, PW'(32'hA + i)));
    for (int i = 0; i < 3; i++) begin
      v_i = 1'b1; data_i = PW'(32'hA + i);
      cycle();
      n_tests++;
      if (!(s_ready && s_memv)) begin
        n_fail++;
        $display("FAIL b2b_same_cycle[%0d] got rdy=%b v=%b, expected 1 1", i, s_ready, s_memv);
      end
    end
    v_i = 1'b0; en_i = 1'b0;
    cycle();
    drain_check("b2b");
  endtask

  task automatic test_gap();
    reset_dut();
    en_i = 1'b1; record_gaps_i = 1'b1;
    repeat (5) cycle();
    exp_q.push_back(word(0, 5, 5));
    exp_q.push_back(word(1, 4, 0));
    exp_q.push_back(word(2, 1, 32'h55));
    v_i = 1'b1; data_i = 32'h55;
    cycle();
    n_tests++;
    if (!(s_ready && !s_memv)) begin
      n_fail++;
      $display("FAIL gap_handshake got rdy=%b v=%b, expected 1 0", s_ready, s_memv);
    end
    data_i = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (s_ready !== 1'b0 || s_memv !== 1'b1) begin
        n_fail++;
        $display("FAIL gap_seq[%0d] got rdy=%b v=%b, expected 0 1", i, s_ready, s_memv);
      end
    end
    v_i = 1'b0;
    cycle();
    n_tests++;
    if (s_ready !== 1'b1 || s_memv !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_return got rdy=%b v=%b, expected 1 0", s_ready, s_memv);
    end
    en_i = 1'b0;
    drain_check("gap");
  endtask

  task automatic test_capacity();
    int hs;
    hs = 0;
    reset_dut();
    en_i = 1'b1; record_gaps_i = 1'b0;
    for (int i = 0; i < 61; i++) exp_q.push_back(word(i, 1, PW'(i)));
    exp_q.push_back(word(61, 3, 0));
    for (int i = 0; i < 70; i++) begin
      v_i = 1'b1; data_i = PW'(i);
      cycle();
      if (s_ready) hs++;
    end
    v_i = 1'b0;
    n_tests++;
    if (hs != 61) begin
      n_fail++;
      $display("FAIL cap_handshakes got %0d, expected 61", hs);
    end
    n_tests++;
    if (done_o !== 1'b1 || overflow_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_flags got done=%b ovf=%b, expected 1 1", done_o, overflow_o);
    end
    drain_check("cap");
  endtask

  task automatic test_collision();
    reset_dut();
    en_i = 1'b1; record_gaps_i = 1'b1;
    exp_q.push_back(word(0, 5, 2));
    exp_q.push_back(word(1, 4, 0));
    exp_q.push_back(word(2, 1, 32'h77));
    exp_q.push_back(word(3, 3, 0));
    repeat (2) cycle();
    v_i = 1'b1; finish_i = 1'b1; data_i = 32'h77;
    cycle();
    v_i = 1'b0; finish_i = 1'b0;
    repeat (6) cycle();
    n_tests++;
    if (done_o !== 1'b1 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_flags got done=%b ovf=%b, expected 1 0", done_o, overflow_o);
    end
    drain_check("coll");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    en_i = 1'b1; record_gaps_i = 1'b1;
    exp_q.push_back(word(0, 5, 3));
    repeat (3) cycle();
    v_i = 1'b1; data_i = 32'h99;
    cycle();
    v_i = 1'b0;
    cycle();                      // GAP_INIT written; now in GAP_WAIT
    reset_i = 1'b1;
    #1;
    n_tests++;
    if ({ready_and_o, mem_v_o, done_o, overflow_o, mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got rdy=%b v=%b done=%b ovf=%b addr=%0d, expected all 0",
               ready_and_o, mem_v_o, done_o, overflow_o, mem_addr_o);
    end
    cycle();
    en_i = 1'b0; reset_i = 1'b0;
    repeat (4) cycle();
    drain_check("rstmid");
  endtask

  // Record a mixed trace, then walk it the way trace replay would, rebuilding
  // the (gap, data) stream the bench drove.
  task automatic test_round_trip();
    int            gaps [4];
    logic [PW-1:0] dats [4];
    int k, cur_gap, bound;
    logic err, fin, pend_init;
    logic [3:0] op;
    gaps = '{0, 3, 0, 1};
    dats = '{32'hC0FFEE, 32'h1111, 32'h2222, 32'h3333};
    reset_dut();
    exp_q.push_back(word(0, 1, 32'hC0FFEE));
    exp_q.push_back(word(1, 5, 3));
    exp_q.push_back(word(2, 4, 0));
    exp_q.push_back(word(3, 1, 32'h1111));
    exp_q.push_back(word(4, 1, 32'h2222));
    exp_q.push_back(word(5, 5, 1));
    exp_q.push_back(word(6, 4, 0));
    exp_q.push_back(word(7, 1, 32'h3333));
    exp_q.push_back(word(8, 3, 0));
    en_i = 1'b1; record_gaps_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v_i = 1'b0;
      repeat (gaps[i]) cycle();
      v_i = 1'b1; data_i = dats[i];
      bound = 0;
      do begin cycle(); bound++; end while (!s_ready && bound < 10);
      if (!s_ready) begin
        n_tests++; n_fail++;
        $display("FAIL rt_handshake_timeout item=%0d", i);
      end
    end
    v_i = 1'b0; finish_i = 1'b1;
    cycle();
    finish_i = 1'b0;
    repeat (8) cycle();
    drain_check("rt");

    k = 0; cur_gap = 0; err = 1'b0; fin = 1'b0; pend_init = 1'b0;
    for (int a = 0; a < (1<<AW) && !fin && !err; a++) begin
      op = rec_mem[a][DW-1:PW];
      case (op)
        4'd5: begin cur_gap = int'(rec_mem[a][PW-1:0]); pend_init = 1'b1; end
        4'd4: if (!pend_init) err = 1'b1;
        4'd1: begin
          if (k >= 4 || rec_mem[a][PW-1:0] !== dats[k] || cur_gap != gaps[k]) err = 1'b1;
          k++; cur_gap = 0; pend_init = 1'b0;
        end
        4'd3: fin = 1'b1;
        default: err = 1'b1;
      endcase
    end
    n_tests++;
    if (fin !== 1'b1 || err !== 1'b0 || k != 4) begin
      n_fail++;
      $display("FAIL rt_replay got done=%b error=%b recv=%0d, expected 1 0 4", fin, err, k);
    end
    n_tests++;
    if (done_o !== 1'b1 || overflow_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rt_flags got done=%b ovf=%b, expected 1 0", done_o, overflow_o);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_capacity();
    test_collision();
    test_reset_mid();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "timeout");
  end

endmodule
